gba_line_cache: RTL and testbench
=================================

# gba_line_cache

Four-line ring buffer between GBA pixel capture and the HDMI image generator. The write side stores incoming 240-pixel GBA lines. The read side answers the generator's `curPxl`/`nextLine`/`cacheUpdate` requests with a clamped 3x3 RGB neighbourhood around the requested pixel. It also reports `sameLine` whenever the reader must not advance, and forwards the frame-start pulse.

## Interface

**Parameters**
- `LINE_WIDTH`, 240: pixels per GBA line.
- `LINE_COUNT`, 160: lines per GBA frame.
- `SLOTS`, 4: ring depth in lines; fixed, power of two.

**Ports**
- `pxlClk` in 1: pixel clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high. Clock is `pxlClk`.
- `pxlValidIn` in 1: one captured pixel on this cycle.
- `redIn`, `greenIn`, `blueIn` in 8 each: captured pixel colour.
- `newFrameIn` in 1: frame-start pulse from capture.
- `curPxl` in 8: read x index from the generator.
- `nextLine` in 1: one-cycle pulse; advance the read line.
- `cacheUpdate` in 1: one-cycle pulse at the end of each HDMI line; commits the slot mapping.
- `{prev,cur,next}Line{Prev,Cur,Next}Pxl{Red,Green,Blue}Out` out 8 each: 27 registered neighbourhood outputs.
- `sameLine` out 1: 1 means the reader must not advance.
- `newFrameOut` out 1: `newFrameIn` delayed by one cycle.
- `overrunOut` out 1: sticky writer-overran-reader flag.

## Operation

**Write side**
- Counters: `wrX` (0..239), `wrLine` (0..159), `linesDone` (0..160).
- On `pxlValidIn`, write the pixel to slot `wrLine mod 4`, address `wrX`, then increment `wrX`.
- At `wrX == 239`:
  - `wrX` returns to 0.
  - `wrLine` increments, saturating at 159.
  - `linesDone` increments, saturating at 160.
- Pixels arriving while `linesDone == 160` are dropped.

**Read side**
- Counter `rdLine` (0..159).
- `nextLine` increments `rdLine` only when `sameLine == 0`. It saturates at 159. A pulse while `sameLine == 1` is ignored.
- On `cacheUpdate`, latch the slots for lines `rdLine-1`, `rdLine` and `rdLine+1`, each mod 4.
  - If `nextLine` arrives in the same cycle, the latch uses the incremented `rdLine`.
- Clamping:
  - At `rdLine == 0`, the prev line is the cur line.
  - At `rdLine == 159`, the next line is the cur line.
  - `curPxl > 239` is treated as 239.
  - At x == 0, prev x = cur x. At x == 239, next x = cur x.
- `sameLine` is registered and equals `linesDone < min(rdLine+3, 160)`.

**Frame start**
- On `newFrameIn`:
  - Clear `wrX`, `wrLine`, `linesDone`, `rdLine`, the slot latch (prev/cur/next = slot 0) and `overrunOut`.
  - `pxlValidIn` in the same cycle is written as x=0 of line 0 of the new frame.
  - `newFrameIn` overrides a simultaneous end-of-line or `nextLine`.

**Overrun**
- `overrunOut` is set when a write targets the slot currently latched as prev, cur or next line, with `wrLine > rdLine + 1`.
- The write still proceeds.
- The flag holds until `newFrameIn` or `rst`.

**Reset values**
- All 27 colour outputs = 0.
- `sameLine` = 1.
- `newFrameOut` = 0, `overrunOut` = 0.
- All counters = 0.
- RAM contents are undefined.

## Timing

- Read latency is 2 cycles: `curPxl` sampled at cycle t produces the neighbourhood on the outputs at t+2, using the slot latch in effect at t.
- Write-to-read: a pixel written at cycle t is readable by a `curPxl` sampled at t+1 or later.
- `sameLine` reflects `linesDone`/`rdLine` changes one cycle after they occur.
- `newFrameOut` follows `newFrameIn` by exactly 1 cycle.
- Storage is 4x240x24 bits. It must sustain nine reads and one write per cycle; distributed RAM or register replication is acceptable.

## Configuration

- `LINECACHE_NEIGHBOUR_EN` defined:
  - Full 3x3 neighbourhood as specified.
  - `sameLine` is as specified above.
- `LINECACHE_NEIGHBOUR_EN` undefined:
  - Only the cur line is read.
  - All nine pixel positions of every colour output equal `curLineCurPxl`.
  - `sameLine = linesDone < min(rdLine+2, 160)`.
  - The overrun check covers the cur slot only.
  - Latency stays at 2 cycles.

## Test plan

- **Reset:** assert `rst` for 3 cycles. Required: all colour outputs 0, `sameLine` = 1, `newFrameOut` = 0, `overrunOut` = 0.
- **Fill and read:** `newFrameIn`, then write lines 0-2 with pixel value = {x, line, 8'h55}. Pulse `cacheUpdate`, drive `curPxl` = 10. Required at t+2: `curLineCurPxlRed` = 10, `curLineNextPxlRed` = 11, `nextLineCurPxlGreen` = 1, `prevLineCurPxlGreen` = 0 (clamped).
- **Edge clamp:** `curPxl` = 0 gives prev x = 0; `curPxl` = 239 and `curPxl` = 250 both give next x = 239 and cur x = 239.
- **Flow control:** with 2 lines written and `rdLine` = 0, `sameLine` = 1 and `nextLine` is ignored. Writing line 2 drops `sameLine` to 0 one cycle later, after which `nextLine` sets `rdLine` = 1.
- **Frame end and resync:** read to `rdLine` = 159 and check next line = cur line. Then `newFrameIn` in the same cycle as `nextLine` and a valid pixel. Required: `rdLine` = 0, pixel stored at line 0 x 0, `newFrameOut` high exactly 1 cycle later.
- **Overrun:** hold `rdLine` = 0 and write 4 lines. Required: `overrunOut` = 1 on the first write to line 3, and it stays 1 until the next `newFrameIn`.

Source files
------------

// File: rtl/gba_line_cache.sv
// rtl/gba_line_cache.sv - four-line GBA ring buffer serving a clamped 3x3 RGB neighbourhood to the HDMI generator
// Build option LINECACHE_NEIGHBOUR_EN: full 3x3 read; when undefined only the cur line pixel is read.
module gba_line_cache #(
  parameter int LINE_WIDTH = 240,
  parameter int LINE_COUNT = 160,
  parameter int SLOTS      = 4
) (
  input  logic       pxlClk,
  input  logic       rst,
  input  logic       pxlValidIn,
  input  logic [7:0] redIn,
  input  logic [7:0] greenIn,
  input  logic [7:0] blueIn,
  input  logic       newFrameIn,
  input  logic [7:0] curPxl,
  input  logic       nextLine,
  input  logic       cacheUpdate,
  output logic [7:0] prevLinePrevPxlRedOut,
  output logic [7:0] prevLinePrevPxlGreenOut,
  output logic [7:0] prevLinePrevPxlBlueOut,
  output logic [7:0] prevLineCurPxlRedOut,
  output logic [7:0] prevLineCurPxlGreenOut,
  output logic [7:0] prevLineCurPxlBlueOut,
  output logic [7:0] prevLineNextPxlRedOut,
  output logic [7:0] prevLineNextPxlGreenOut,
  output logic [7:0] prevLineNextPxlBlueOut,
  output logic [7:0] curLinePrevPxlRedOut,
  output logic [7:0] curLinePrevPxlGreenOut,
  output logic [7:0] curLinePrevPxlBlueOut,
  output logic [7:0] curLineCurPxlRedOut,
  output logic [7:0] curLineCurPxlGreenOut,
  output logic [7:0] curLineCurPxlBlueOut,
  output logic [7:0] curLineNextPxlRedOut,
  output logic [7:0] curLineNextPxlGreenOut,
  output logic [7:0] curLineNextPxlBlueOut,
  output logic [7:0] nextLinePrevPxlRedOut,
  output logic [7:0] nextLinePrevPxlGreenOut,
  output logic [7:0] nextLinePrevPxlBlueOut,
  output logic [7:0] nextLineCurPxlRedOut,
  output logic [7:0] nextLineCurPxlGreenOut,
  output logic [7:0] nextLineCurPxlBlueOut,
  output logic [7:0] nextLineNextPxlRedOut,
  output logic [7:0] nextLineNextPxlGreenOut,
  output logic [7:0] nextLineNextPxlBlueOut,
  output logic       sameLine,
  output logic       newFrameOut,
  output logic       overrunOut
);

  localparam int X_W = 8;
  localparam int L_W = 8;
  localparam int S_W = $clog2(SLOTS);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);
  localparam logic [L_W-1:0] L_LAST = L_W'(LINE_COUNT - 1);
  localparam logic [L_W-1:0] L_FULL = L_W'(LINE_COUNT);
`ifdef LINECACHE_NEIGHBOUR_EN
  localparam logic [L_W:0] LOOKAHEAD = (L_W+1)'(3);
`else
  localparam logic [L_W:0] LOOKAHEAD = (L_W+1)'(2);
`endif

  logic [23:0]    mem [SLOTS][LINE_WIDTH];

  logic [X_W-1:0] wrX;
  logic [L_W-1:0] wrLine;
  logic [L_W-1:0] linesDone;
  logic [L_W-1:0] rdLine;
  logic [S_W-1:0] slot_cur;

  logic           wr_en;
  logic [X_W-1:0] wr_addr_x;
  logic [S_W-1:0] wr_slot;
  logic           rd_adv;
  logic [L_W-1:0] rd_line_nx;
  logic [L_W:0]   need_lines;
  logic           ovr_hit;
  logic [X_W-1:0] x_cl;

  logic [X_W-1:0] s1_xc;
  logic [S_W-1:0] s1_sc;
  logic [23:0]    nb [9];

`ifdef LINECACHE_NEIGHBOUR_EN
  logic [S_W-1:0] slot_prev;
  logic [S_W-1:0] slot_next;
  logic           lat_first;
  logic           lat_last;
  logic [X_W-1:0] s1_xp;
  logic [X_W-1:0] s1_xn;
  logic [S_W-1:0] s1_sp;
  logic [S_W-1:0] s1_sn;
`else
  logic [23:0]    cur_q;
`endif

  // A pixel arriving with the frame-start pulse lands at x=0 of line 0.
  always_comb begin
    wr_addr_x = newFrameIn ? '0 : wrX;
    wr_slot   = newFrameIn ? '0 : wrLine[S_W-1:0];
    wr_en     = pxlValidIn && (newFrameIn || (linesDone != L_FULL));
  end

  always_ff @(posedge pxlClk) begin
    if (wr_en) begin
      mem[wr_slot][wr_addr_x] <= {redIn, greenIn, blueIn};
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      wrX       <= '0;
      wrLine    <= '0;
      linesDone <= '0;
    end else if (newFrameIn) begin
      wrX       <= pxlValidIn ? X_W'(1) : '0;
      wrLine    <= '0;
      linesDone <= '0;
    end else if (wr_en) begin
      if (wrX == X_LAST) begin
        wrX       <= '0;
        linesDone <= linesDone + 1'b1;
        if (wrLine != L_LAST) begin
          wrLine <= wrLine + 1'b1;
        end
      end else begin
        wrX <= wrX + 1'b1;
      end
    end
  end

  always_comb begin
    rd_adv     = nextLine && !sameLine && (rdLine != L_LAST);
    rd_line_nx = rd_adv ? rdLine + 1'b1 : rdLine;
  end

  // Slots are latched raw (mod SLOTS); top/bottom clamping is applied on read via the latched flags.
  always_ff @(posedge pxlClk) begin
    if (rst || newFrameIn) begin
      rdLine    <= '0;
      slot_cur  <= '0;
`ifdef LINECACHE_NEIGHBOUR_EN
      slot_prev <= '0;
      slot_next <= '0;
      lat_first <= 1'b1;
      lat_last  <= 1'b0;
`endif
    end else begin
      rdLine <= rd_line_nx;
      if (cacheUpdate) begin
        slot_cur  <= rd_line_nx[S_W-1:0];
`ifdef LINECACHE_NEIGHBOUR_EN
        slot_prev <= rd_line_nx[S_W-1:0] - 1'b1;
        slot_next <= rd_line_nx[S_W-1:0] + 1'b1;
        lat_first <= (rd_line_nx == '0);
        lat_last  <= (rd_line_nx == L_LAST);
`endif
      end
    end
  end

  always_comb begin
    need_lines = {1'b0, rdLine} + LOOKAHEAD;
    if (need_lines > {1'b0, L_FULL}) begin
      need_lines = {1'b0, L_FULL};
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      sameLine <= 1'b1;
    end else begin
      sameLine <= ({1'b0, linesDone} < need_lines);
    end
  end

  always_comb begin
    ovr_hit = (wr_slot == slot_cur);
`ifdef LINECACHE_NEIGHBOUR_EN
    ovr_hit = ovr_hit || (wr_slot == slot_prev) || (wr_slot == slot_next);
`endif
  end

  always_ff @(posedge pxlClk) begin
    if (rst || newFrameIn) begin
      overrunOut <= 1'b0;
    end else if (wr_en && ovr_hit && ({1'b0, wrLine} > ({1'b0, rdLine} + 1'b1))) begin
      overrunOut <= 1'b1;
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      newFrameOut <= 1'b0;
    end else begin
      newFrameOut <= newFrameIn;
    end
  end

  always_comb begin
    x_cl = (curPxl > X_LAST) ? X_LAST : curPxl;
  end

  // Stage 1: resolve clamped addresses against the slot latch in effect this cycle.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      s1_xc <= '0;
      s1_sc <= '0;
`ifdef LINECACHE_NEIGHBOUR_EN
      s1_xp <= '0;
      s1_xn <= '0;
      s1_sp <= '0;
      s1_sn <= '0;
`endif
    end else begin
      s1_xc <= x_cl;
      s1_sc <= slot_cur;
`ifdef LINECACHE_NEIGHBOUR_EN
      s1_xp <= (x_cl == '0) ? x_cl : x_cl - 1'b1;
      s1_xn <= (x_cl == X_LAST) ? x_cl : x_cl + 1'b1;
      s1_sp <= lat_first ? slot_cur : slot_prev;
      s1_sn <= lat_last ? slot_cur : slot_next;
`endif
    end
  end

  // Stage 2: nine parallel reads into the output registers.
`ifdef LINECACHE_NEIGHBOUR_EN
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        nb[i] <= '0;
      end
    end else begin
      nb[0] <= mem[s1_sp][s1_xp];
      nb[1] <= mem[s1_sp][s1_xc];
      nb[2] <= mem[s1_sp][s1_xn];
      nb[3] <= mem[s1_sc][s1_xp];
      nb[4] <= mem[s1_sc][s1_xc];
      nb[5] <= mem[s1_sc][s1_xn];
      nb[6] <= mem[s1_sn][s1_xp];
      nb[7] <= mem[s1_sn][s1_xc];
      nb[8] <= mem[s1_sn][s1_xn];
    end
  end
`else
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      cur_q <= '0;
    end else begin
      cur_q <= mem[s1_sc][s1_xc];
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      nb[i] = cur_q;
    end
  end
`endif

  assign prevLinePrevPxlRedOut   = nb[0][23:16];
  assign prevLinePrevPxlGreenOut = nb[0][15:8];
  assign prevLinePrevPxlBlueOut  = nb[0][7:0];
  assign prevLineCurPxlRedOut    = nb[1][23:16];
  assign prevLineCurPxlGreenOut  = nb[1][15:8];
  assign prevLineCurPxlBlueOut   = nb[1][7:0];
  assign prevLineNextPxlRedOut   = nb[2][23:16];
  assign prevLineNextPxlGreenOut = nb[2][15:8];
  assign prevLineNextPxlBlueOut  = nb[2][7:0];
  assign curLinePrevPxlRedOut    = nb[3][23:16];
  assign curLinePrevPxlGreenOut  = nb[3][15:8];
  assign curLinePrevPxlBlueOut   = nb[3][7:0];
  assign curLineCurPxlRedOut     = nb[4][23:16];
  assign curLineCurPxlGreenOut   = nb[4][15:8];
  assign curLineCurPxlBlueOut    = nb[4][7:0];
  assign curLineNextPxlRedOut    = nb[5][23:16];
  assign curLineNextPxlGreenOut  = nb[5][15:8];
  assign curLineNextPxlBlueOut   = nb[5][7:0];
  assign nextLinePrevPxlRedOut   = nb[6][23:16];
  assign nextLinePrevPxlGreenOut = nb[6][15:8];
  assign nextLinePrevPxlBlueOut  = nb[6][7:0];
  assign nextLineCurPxlRedOut    = nb[7][23:16];
  assign nextLineCurPxlGreenOut  = nb[7][15:8];
  assign nextLineCurPxlBlueOut   = nb[7][7:0];
  assign nextLineNextPxlRedOut   = nb[8][23:16];
  assign nextLineNextPxlGreenOut = nb[8][15:8];
  assign nextLineNextPxlBlueOut  = nb[8][7:0];

endmodule

// File: tb/tb_gba_line_cache.sv
// tb/tb_gba_line_cache.sv - directed scoreboard bench for gba_line_cache
`timescale 1ns/1ps
module tb_gba_line_cache;

`ifdef LINECACHE_NEIGHBOUR_EN
  localparam int LA = 3;
  localparam int OVR_LINE = 3;
`else
  localparam int LA = 2;
  localparam int OVR_LINE = 4;
`endif
  localparam logic [215:0] ALL_MASK = {216{1'b1}};
  localparam logic [215:0] CUR_MASK = {{96{1'b0}}, {24{1'b1}}, {96{1'b0}}};

  logic       pxlClk = 1'b0;
  logic       rst, pxlValidIn, newFrameIn, nextLine, cacheUpdate;
  logic [7:0] redIn, greenIn, blueIn, curPxl;
  logic [7:0] prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut;
  logic [7:0] prevLineCurPxlRedOut, prevLineCurPxlGreenOut, prevLineCurPxlBlueOut;
  logic [7:0] prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut;
  logic [7:0] curLinePrevPxlRedOut, curLinePrevPxlGreenOut, curLinePrevPxlBlueOut;
  logic [7:0] curLineCurPxlRedOut, curLineCurPxlGreenOut, curLineCurPxlBlueOut;
  logic [7:0] curLineNextPxlRedOut, curLineNextPxlGreenOut, curLineNextPxlBlueOut;
  logic [7:0] nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut;
  logic [7:0] nextLineCurPxlRedOut, nextLineCurPxlGreenOut, nextLineCurPxlBlueOut;
  logic [7:0] nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut;
  logic       sameLine, newFrameOut, overrunOut;
  logic [215:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [215:0] exp_q[$];
  logic [215:0] mask_q[$];
  string        tag_q[$];

  always #5 pxlClk = ~pxlClk;

  gba_line_cache dut (
    .pxlClk(pxlClk), .rst(rst), .pxlValidIn(pxlValidIn),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .newFrameIn(newFrameIn), .curPxl(curPxl), .nextLine(nextLine), .cacheUpdate(cacheUpdate),
    .prevLinePrevPxlRedOut(prevLinePrevPxlRedOut), .prevLinePrevPxlGreenOut(prevLinePrevPxlGreenOut),
    .prevLinePrevPxlBlueOut(prevLinePrevPxlBlueOut),
    .prevLineCurPxlRedOut(prevLineCurPxlRedOut), .prevLineCurPxlGreenOut(prevLineCurPxlGreenOut),
    .prevLineCurPxlBlueOut(prevLineCurPxlBlueOut),
    .prevLineNextPxlRedOut(prevLineNextPxlRedOut), .prevLineNextPxlGreenOut(prevLineNextPxlGreenOut),
    .prevLineNextPxlBlueOut(prevLineNextPxlBlueOut),
    .curLinePrevPxlRedOut(curLinePrevPxlRedOut), .curLinePrevPxlGreenOut(curLinePrevPxlGreenOut),
    .curLinePrevPxlBlueOut(curLinePrevPxlBlueOut),
    .curLineCurPxlRedOut(curLineCurPxlRedOut), .curLineCurPxlGreenOut(curLineCurPxlGreenOut),
    .curLineCurPxlBlueOut(curLineCurPxlBlueOut),
    .curLineNextPxlRedOut(curLineNextPxlRedOut), .curLineNextPxlGreenOut(curLineNextPxlGreenOut),
    .curLineNextPxlBlueOut(curLineNextPxlBlueOut),
    .nextLinePrevPxlRedOut(nextLinePrevPxlRedOut), .nextLinePrevPxlGreenOut(nextLinePrevPxlGreenOut),
    .nextLinePrevPxlBlueOut(nextLinePrevPxlBlueOut),
    .nextLineCurPxlRedOut(nextLineCurPxlRedOut), .nextLineCurPxlGreenOut(nextLineCurPxlGreenOut),
    .nextLineCurPxlBlueOut(nextLineCurPxlBlueOut),
    .nextLineNextPxlRedOut(nextLineNextPxlRedOut), .nextLineNextPxlGreenOut(nextLineNextPxlGreenOut),
    .nextLineNextPxlBlueOut(nextLineNextPxlBlueOut),
    .sameLine(sameLine), .newFrameOut(newFrameOut), .overrunOut(overrunOut)
  );

  assign obs = {prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
                prevLineCurPxlRedOut, prevLineCurPxlGreenOut, prevLineCurPxlBlueOut,
                prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
                curLinePrevPxlRedOut, curLinePrevPxlGreenOut, curLinePrevPxlBlueOut,
                curLineCurPxlRedOut, curLineCurPxlGreenOut, curLineCurPxlBlueOut,
                curLineNextPxlRedOut, curLineNextPxlGreenOut, curLineNextPxlBlueOut,
                nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
                nextLineCurPxlRedOut, nextLineCurPxlGreenOut, nextLineCurPxlBlueOut,
                nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut};

  function automatic logic [23:0] pix(input int x, input int l);
    logic [7:0] xb, lb;
    xb = x[7:0];
    lb = l[7:0];
    return {xb, lb, 8'h55};
  endfunction

  function automatic logic [215:0] nb_exp(input int x, input int rd);
    int xc;
    int xs[3];
    int ls[3];
    logic [215:0] r;
    xc = (x > 239) ? 239 : x;
`ifdef LINECACHE_NEIGHBOUR_EN
    xs = '{(xc == 0) ? 0 : xc - 1, xc, (xc == 239) ? 239 : xc + 1};
    ls = '{(rd == 0) ? 0 : rd - 1, rd, (rd == 159) ? 159 : rd + 1};
`else
    xs = '{xc, xc, xc};
    ls = '{rd, rd, rd};
`endif
    r = '0;
    for (int li = 0; li < 3; li++)
      for (int pi = 0; pi < 3; pi++)
        r[215 - 24*(li*3 + pi) -: 24] = pix(xs[pi], ls[li]);
    return r;
  endfunction

  task automatic tick;
    @(posedge pxlClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [215:0] o, input logic [215:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic read_nb(input string tag, input int x, input logic [215:0] e, input logic [215:0] m);
    logic [215:0] ee, mm;
    string t;
    curPxl = x[7:0];
    exp_q.push_back(e & m);
    mask_q.push_back(m);
    tag_q.push_back(tag);
    tick;
    tick;
    ee = exp_q.pop_front();
    mm = mask_q.pop_front();
    t  = tag_q.pop_front();
    check(t, obs & mm, ee);
  endtask

  task automatic write_line(input int line, input int x0);
    for (int x = x0; x < 240; x++) begin
      pxlValidIn = 1'b1;
      {redIn, greenIn, blueIn} = pix(x, line);
      tick;
    end
    pxlValidIn = 1'b0;
  endtask

  task automatic pulse_adv;
    nextLine = 1'b1;
    cacheUpdate = 1'b1;
    tick;
    nextLine = 1'b0;
    cacheUpdate = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int rd_m;
    int ld;
    int guard;
    logic exp_same;
    logic [215:0] e_rs;

    rst = 1'b1; pxlValidIn = 1'b0; newFrameIn = 1'b0; nextLine = 1'b0; cacheUpdate = 1'b0;
    redIn = '0; greenIn = '0; blueIn = '0; curPxl = '0;
    repeat (3) tick;
    check("reset_colours", obs, '0);
    check("reset_sameLine", sameLine, 1);
    check("reset_newFrameOut", newFrameOut, 0);
    check("reset_overrun", overrunOut, 0);
    rst = 1'b0;

    newFrameIn = 1'b1;
    tick;
    newFrameIn = 1'b0;
    check("nf_out_high", newFrameOut, 1);
    tick;
    check("nf_out_low", newFrameOut, 0);

    for (int l = 0; l < LA - 1; l++) write_line(l, 0);
    tick;
    check("flow_sameLine_hold", sameLine, 1);
    pulse_adv;
    read_nb("flow_nextLine_ignored", 10, nb_exp(10, 0), ALL_MASK);

    write_line(LA - 1, 0);
    check("flow_sameLine_lag", sameLine, 1);
    tick;
    check("flow_sameLine_drop", sameLine, 0);

    read_nb("fill_x10", 10, nb_exp(10, 0), ALL_MASK);
    read_nb("clamp_x0", 0, nb_exp(0, 0), ALL_MASK);
    read_nb("clamp_x239", 239, nb_exp(239, 0), ALL_MASK);
    read_nb("clamp_x250", 250, nb_exp(250, 0), ALL_MASK);

    pulse_adv;
    read_nb("adv_rd1", 10, nb_exp(10, 1), ALL_MASK);

    rd_m = 1;
    ld = LA;
    for (int l = LA; l < 160; l++) begin
      write_line(l, 0);
      ld++;
      tick;
      exp_same = (ld < ((rd_m + LA < 160) ? rd_m + LA : 160));
      check("walk_sameLine", sameLine, exp_same);
      pulse_adv;
      if (!exp_same && rd_m < 159) rd_m++;
    end
    guard = 0;
    while (rd_m < 159 && guard < 300) begin
      tick;
      exp_same = (ld < ((rd_m + LA < 160) ? rd_m + LA : 160));
      check("tail_sameLine", sameLine, exp_same);
      pulse_adv;
      if (!exp_same) rd_m++;
      guard++;
    end
    check("tail_reached_159", rd_m, 159);
    tick;
    pulse_adv;

    for (int i = 0; i < 5; i++) begin
      pxlValidIn = 1'b1;
      {redIn, greenIn, blueIn} = 24'hDEAD00 + 24'(i);
      tick;
    end
    pxlValidIn = 1'b0;
    read_nb("end_drop_x0", 0, nb_exp(0, 159), ALL_MASK);
    read_nb("end_x10", 10, nb_exp(10, 159), ALL_MASK);
    read_nb("end_x239", 239, nb_exp(239, 159), ALL_MASK);

    newFrameIn = 1'b1; nextLine = 1'b1; pxlValidIn = 1'b1;
    {redIn, greenIn, blueIn} = 24'hAABBCC;
    tick;
    newFrameIn = 1'b0; nextLine = 1'b0; pxlValidIn = 1'b0;
    check("resync_nf_high", newFrameOut, 1);
    check("resync_overrun_clear", overrunOut, 0);
    tick;
    check("resync_nf_low", newFrameOut, 0);
    cacheUpdate = 1'b1;
    tick;
    cacheUpdate = 1'b0;
    e_rs = '0;
    e_rs[119:96] = 24'hAABBCC;
    read_nb("resync_pixel_l0x0", 0, e_rs, CUR_MASK);

    write_line(0, 1);
    for (int l = 1; l < OVR_LINE; l++) write_line(l, 0);
    check("ovr_before", overrunOut, 0);
    pxlValidIn = 1'b1;
    {redIn, greenIn, blueIn} = pix(0, OVR_LINE);
    tick;
    pxlValidIn = 1'b0;
    check("ovr_first_write", overrunOut, 1);
    write_line(OVR_LINE, 200);
    check("ovr_sticky", overrunOut, 1);
    newFrameIn = 1'b1;
    tick;
    newFrameIn = 1'b0;
    check("ovr_cleared_by_frame", overrunOut, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
